// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 4-channel mux scan controller.
// Holds the scan FSM state type and the lowest-enabled-channel helper.
package mux_scan_pkg;

    localparam int NCH  = 4;
    localparam int CH_W = 2;

    typedef enum logic [1:0] {
        IDLE,
        DWELL,
        CAPTURE
    } scan_state_t;

    // Lowest set bit of the mask; returns 0 for an empty mask.
    function automatic logic [CH_W-1:0] first_ch(input logic [NCH-1:0] mask);
        first_ch = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (mask[k]) begin
                first_ch = CH_W'(k);
            end
        end
    endfunction

endpackage

// File: rtl/mux4.sv
// Downstream 4:1 mux with enable; output is forced low when disabled.
module mux4 (
    input  logic [3:0] x,
    input  logic [1:0] s,
    input  logic       en,
    output logic       y
);

    assign y = en & x[s];

endmodule

// File: rtl/mux_next_ch.sv
// Finds the next enabled channel above the current one.
// The last flag is set when no higher enabled channel exists.
module mux_next_ch
    import mux_scan_pkg::*;
(
    input  logic [NCH-1:0]  mask,
    input  logic [CH_W-1:0] cur_ch,
    output logic [CH_W-1:0] next_ch,
    output logic            last
);

    always_comb begin
        next_ch = cur_ch;
        last    = 1'b1;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (mask[k] && (k > int'(cur_ch))) begin
                next_ch = CH_W'(k);
                last    = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans the enabled inputs of a 4:1 mux, holding each select for a dwell
// period and capturing the mux output into a per-channel sample word.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               cont,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [NCH-1:0]     ch_mask,
    input  logic               y_in,
    output logic [CH_W-1:0]    sel,
    output logic               en,
    output logic               busy,
    output logic [NCH-1:0]     sample,
    output logic               sample_valid
);

    scan_state_t        state;
    logic [NCH-1:0]     mask_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] cnt;
    logic [NCH-1:0]     shadow;
    logic [NCH-1:0]     shadow_next;
    logic [CH_W-1:0]    next_ch;
    logic               last_ch;

    // A dwell of zero behaves as one, so the reload value never underflows.
    function automatic logic [DWELL_W-1:0] reload_val(input logic [DWELL_W-1:0] d);
        reload_val = (d == '0) ? '0 : d - 1'b1;
    endfunction

    mux_next_ch u_next_ch (
        .mask    (mask_q),
        .cur_ch  (sel),
        .next_ch (next_ch),
        .last    (last_ch)
    );

    always_comb begin
        shadow_next      = shadow;
        shadow_next[sel] = y_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            mask_q       <= '0;
            dwell_q      <= '0;
            cnt          <= '0;
            shadow       <= '0;
            sel          <= '0;
            en           <= 1'b0;
            busy         <= 1'b0;
            sample       <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        if (ch_mask != '0) begin
                            mask_q  <= ch_mask;
                            dwell_q <= dwell;
                            sel     <= first_ch(ch_mask);
                            en      <= 1'b1;
                            busy    <= 1'b1;
                            cnt     <= reload_val(dwell);
                            shadow  <= '0;
                            state   <= DWELL;
                        end else begin
                            sample       <= '0;
                            sample_valid <= 1'b1;
                        end
                    end
                end

                DWELL: begin
                    if (stop) begin
                        en    <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (cnt == '0) begin
                        state <= CAPTURE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                CAPTURE: begin
                    // Stop discards the capture of this cycle entirely.
                    if (stop) begin
                        en    <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (!last_ch) begin
                        shadow <= shadow_next;
                        sel    <= next_ch;
                        cnt    <= reload_val(dwell_q);
                        state  <= DWELL;
                    end else begin
                        sample       <= shadow_next & mask_q;
                        sample_valid <= 1'b1;
                        shadow       <= shadow_next;
                        mask_q       <= ch_mask;
                        dwell_q      <= dwell;
                        if (cont && (ch_mask != '0)) begin
                            sel    <= first_ch(ch_mask);
                            cnt    <= reload_val(dwell);
                            shadow <= '0;
                            state  <= DWELL;
                        end else begin
                            en    <= 1'b0;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end

                default: begin
                    en    <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench for mux_scan_ctrl: scans are predicted from channel lists
// and dwell arithmetic; sample_valid events are checked by a separate monitor.
module tb_mux_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       cont;
    logic [7:0] dwell;
    logic [3:0] ch_mask;
    logic       y_in;
    logic [1:0] sel;
    logic       en;
    logic       busy;
    logic [3:0] sample;
    logic       sample_valid;
    logic [3:0] x_val;

    typedef struct {
        int         cyc;
        logic [3:0] sample;
    } exp_t;

    exp_t       exp_q[$];
    int         cyc = 0;
    int         n_compared = 0;
    int         n_failed = 0;
    logic [3:0] last_sample = 4'b0000;

    mux_scan_ctrl #(.DWELL_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .cont         (cont),
        .dwell        (dwell),
        .ch_mask      (ch_mask),
        .y_in         (y_in),
        .sel          (sel),
        .en           (en),
        .busy         (busy),
        .sample       (sample),
        .sample_valid (sample_valid)
    );

    mux4 u_mux (
        .x  (x_val),
        .s  (sel),
        .en (en),
        .y  (y_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_compared++;
        if (actual != expected) begin
            n_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: every sample_valid pulse must match the oldest predicted scan result.
    always @(negedge clk) begin
        if (rst_n && sample_valid) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_sample_valid", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("sample_valid_cycle", cyc, e.cyc);
                checkOutput("sample_value", int'(sample), int'(e.sample));
            end
        end
    end

    // Runs one (or n_scans back-to-back) scan and checks sel/en/busy each cycle.
    task automatic applyStimulus(input logic [3:0] mask, input int dw, input logic [3:0] x,
                                 input int n_scans, input int abort_off, input bit abort_rst,
                                 input int busy_start_off);
        int deff;
        int total;
        int s;
        int idx;
        int chans[$];
        deff = (dw == 0) ? 1 : dw;
        for (int k = 0; k < 4; k++) begin
            if (mask[k]) chans.push_back(k);
        end
        total = chans.size() * (deff + 1);

        @(negedge clk);
        x_val   = x;
        ch_mask = mask;
        dwell   = 8'(dw);
        cont    = (n_scans > 1);
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        s = cyc;

        if (chans.size() == 0) begin
            exp_q.push_back('{cyc: s, sample: 4'b0000});
            last_sample = 4'b0000;
            @(negedge clk);
            checkOutput("zero_mask_busy", int'(busy), 0);
            checkOutput("zero_mask_en", int'(en), 0);
            return;
        end

        for (int n = 0; n < n_scans; n++) begin
            exp_q.push_back('{cyc: s + (n + 1) * total, sample: x & mask});
        end

        for (int c = 0; c < n_scans * total; c++) begin
            @(negedge clk);
            if (c == busy_start_off + 1) start = 1'b0;
            idx = (c % total) / (deff + 1);
            checkOutput("scan_sel", int'(sel), chans[idx]);
            checkOutput("scan_en", int'(en), 1);
            checkOutput("scan_busy", int'(busy), 1);
            if (n_scans > 1 && c == (n_scans - 1) * total) cont = 1'b0;
            if (c == busy_start_off) begin
                start = 1'b1;
                dwell = 8'(dw + 2);
            end
            if (c == abort_off) begin
                void'(exp_q.pop_back());
                if (abort_rst) begin
                    #2;
                    rst_n = 1'b0;
                    #1;
                    checkOutput("rst_sel", int'(sel), 0);
                    checkOutput("rst_en", int'(en), 0);
                    checkOutput("rst_busy", int'(busy), 0);
                    checkOutput("rst_sample", int'(sample), 0);
                    checkOutput("rst_sample_valid", int'(sample_valid), 0);
                    last_sample = 4'b0000;
                    @(negedge clk);
                    rst_n = 1'b1;
                end else begin
                    stop = 1'b1;
                    @(negedge clk);
                    stop = 1'b0;
                    checkOutput("stop_en", int'(en), 0);
                    checkOutput("stop_busy", int'(busy), 0);
                    checkOutput("stop_sel_hold", int'(sel), chans[idx]);
                    checkOutput("stop_sample_kept", int'(sample), int'(last_sample));
                end
                return;
            end
        end

        @(negedge clk);
        last_sample = x & mask;
        checkOutput("done_busy", int'(busy), 0);
        checkOutput("done_en", int'(en), 0);
        checkOutput("done_sel_hold", int'(sel), chans[chans.size() - 1]);
        checkOutput("done_sample", int'(sample), int'(last_sample));
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        cont    = 1'b0;
        dwell   = 8'd0;
        ch_mask = 4'h0;
        x_val   = 4'h0;
        #3;
        checkOutput("reset_sel", int'(sel), 0);
        checkOutput("reset_en", int'(en), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_sample", int'(sample), 0);
        checkOutput("reset_sample_valid", int'(sample_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(4'hF, 3, 4'b1010, 1, -1, 1'b0, -1);
        applyStimulus(4'b0101, 0, 4'b1111, 1, -1, 1'b0, -1);
        applyStimulus(4'hF, 2, 4'b0110, 1, 7, 1'b0, -1);
        applyStimulus(4'hF, 1, 4'b1001, 3, -1, 1'b0, -1);
        applyStimulus(4'hF, 2, 4'b1101, 1, 5, 1'b1, -1);
        applyStimulus(4'b1110, 1, 4'b0111, 1, -1, 1'b0, -1);
        applyStimulus(4'h0, 2, 4'b1111, 1, -1, 1'b0, -1);
        applyStimulus(4'b1011, 2, 4'b1110, 1, -1, 1'b0, 2);

        // Stop and start together while idle: nothing may start.
        @(negedge clk);
        ch_mask = 4'hF;
        start   = 1'b1;
        stop    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        checkOutput("stop_start_busy", int'(busy), 0);
        checkOutput("stop_start_en", int'(en), 0);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(4'($urandom_range(0, 15)), int'($urandom_range(0, 4)),
                          4'($urandom), 1, -1, 1'b0, -1);
        end

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
